btn_event_ctrl: RTL and testbench

- Memory-mapped button event controller; sits directly downstream of the per-button debouncers.
- Consumes their single-cycle debounced pulses and latches each into a sticky pending bit.
- Keeps a saturating per-button event count.
- Raises a level interrupt to the RISC-V core, which reads and clears events over a simple single-cycle register bus.

---
 rtl/btn_event_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_btn_event_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_ctrl
// Description : Memory-mapped button event controller. Rising edges on the
//               debounced button pulses set sticky PENDING bits and bump
//               saturating per-button counters (sticky OVF on overflow).
//               A level interrupt is raised for enabled pending events.
//               The core accesses the block over a single-cycle register bus.
//
// Ports       : clock     - system clock
//               reset     - asynchronous active-low reset
//               pb_pulse  - debounced button pulses, one bit per button
//               sel       - bus access strobe (one cycle per access)
//               we        - write enable, qualified by sel
//               addr      - word register index
//               wdata     - write data
//               rdata     - registered read data (valid the cycle after a read)
//               irq       - level interrupt, |(PENDING & ENABLE), registered
//
// Registers   : 0 PENDING (W1C)  1 ENABLE (RW)  2 COUNTS (write clears
//               counters and OVF)  3 OVF (RO)  4 LAST_TS  5 LAST_ID
//
// Option      : define BTN_EVT_TIMESTAMP_EN to include the free-running cycle
//               counter and the LAST_TS / LAST_ID capture registers. Without
//               it, addresses 4-7 read 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module btn_event_ctrl #(
    parameter int NUM_BTN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] pb_pulse,
    input  logic               sel,
    input  logic               we,
    input  logic [2:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               irq
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_COUNTS  = 3'd2;
    localparam logic [2:0] ADDR_OVF     = 3'd3;
    localparam logic [2:0] ADDR_LAST_TS = 3'd4;
    localparam logic [2:0] ADDR_LAST_ID = 3'd5;

    logic [NUM_BTN-1:0] pb_prev;
    logic [NUM_BTN-1:0] evt;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] enable;
    logic [NUM_BTN-1:0] ovf;
    logic [CNT_W-1:0]   count [NUM_BTN];

    logic        wr_pending;
    logic        wr_enable;
    logic        wr_counts;
    logic        rd_access;
    logic [31:0] rd_word;
    logic        unused_wdata;

    // Only the low NUM_BTN write-data bits carry meaning for any register.
    assign unused_wdata = ^wdata[31:NUM_BTN];

    assign wr_pending = sel & we & (addr == ADDR_PENDING);
    assign wr_enable  = sel & we & (addr == ADDR_ENABLE);
    assign wr_counts  = sel & we & (addr == ADDR_COUNTS);
    assign rd_access  = sel & ~we;

    // Edge detect: a level held high produces exactly one event.
    assign evt = pb_pulse & ~pb_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pb_prev <= '0;
        end else begin
            pb_prev <= pb_pulse;
        end
    end

    // Event set has priority over the W1C clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (wr_pending) begin
            pending <= (pending & ~wdata[NUM_BTN-1:0]) | evt;
        end else begin
            pending <= pending | evt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable <= '0;
        end else if (wr_enable) begin
            enable <= wdata[NUM_BTN-1:0];
        end
    end

    // A COUNTS write zeroes every counter first, so a coincident event
    // leaves its counter at 1 and cannot flag overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                count[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (wr_counts) begin
                    count[i] <= evt[i] ? CNT_W'(1) : '0;
                    ovf[i]   <= 1'b0;
                end else if (evt[i]) begin
                    if (&count[i]) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        count[i] <= count[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(pending & enable);
        end
    end

`ifdef BTN_EVT_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] last_ts;
    logic [1:0]  last_id;
    logic [1:0]  first_idx;

    // Lowest-numbered button wins when several fire together.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (evt[i]) begin
                first_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_cnt  <= '0;
            last_ts <= '0;
            last_id <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (|evt) begin
                last_ts <= ts_cnt;
                last_id <= first_idx;
            end
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        case (addr)
            ADDR_PENDING: rd_word[NUM_BTN-1:0] = pending;
            ADDR_ENABLE:  rd_word[NUM_BTN-1:0] = enable;
            ADDR_COUNTS: begin
                for (int i = 0; i < NUM_BTN; i++) begin
                    rd_word[i*CNT_W +: CNT_W] = count[i];
                end
            end
            ADDR_OVF:     rd_word[NUM_BTN-1:0] = ovf;
`ifdef BTN_EVT_TIMESTAMP_EN
            ADDR_LAST_TS: rd_word = last_ts;
            ADDR_LAST_ID: rd_word[1:0] = last_id;
`endif
            default:      rd_word = '0;
        endcase
    end

    // Read data is held between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (rd_access) begin
            rdata <= rd_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_ctrl
// Description : Directed self-checking bench for btn_event_ctrl
//               (NUM_BTN=4, CNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  pb_pulse = '0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    btn_event_ctrl #(.NUM_BTN(4), .CNT_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .pb_pulse (pb_pulse),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq)
    );

    always #10 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        tick();
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic pulse(input logic [3:0] m);
        pb_pulse = m;
        tick();
        pb_pulse = '0;
        tick();
    endtask

    logic [31:0] d;

    initial begin
        // ---------------- reset mid-operation ----------------
        tick(); tick();
        reset = 1'b1;
        tick();
        bus_write(3'd1, 32'hF);
        pulse(4'hF);
        pulse(4'h2);
        bus_read(3'd0, d);
        check("pre_reset_pending", d, 32'h0000000F);
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        #5 reset = 1'b0;
        #1;
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        check("async_reset_rdata", rdata, 32'h0);
        tick(); tick();
        reset = 1'b1;
        tick();
        for (int a = 0; a < 6; a++) begin
            bus_read(3'(a), d);
            check($sformatf("post_reset_reg%0d", a), d, 32'h0);
        end
        check("post_reset_irq", {31'b0, irq}, 32'h0);

        // ---------------- single pulse on button 2 ----------------
        bus_write(3'd1, 32'h4);
        pb_pulse = 4'h4;
        tick();
        pb_pulse = '0;
        check("irq_one_cycle_after_pulse", {31'b0, irq}, 32'h0);
        tick();
        check("irq_two_cycles_after_pulse", {31'b0, irq}, 32'h1);
        bus_read(3'd0, d);
        check("b2_pending", d, 32'h4);
        bus_read(3'd2, d);
        check("b2_counts", d, 32'h00010000);
        bus_write(3'd0, 32'h4);
        check("irq_lag_after_w1c", {31'b0, irq}, 32'h1);
        tick();
        check("irq_clear_after_w1c", {31'b0, irq}, 32'h0);
        bus_read(3'd0, d);
        check("pending_after_w1c", d, 32'h0);

        // ---------------- held input counts once ----------------
        pb_pulse = 4'h1;
        for (int i = 0; i < 100; i++) tick();
        pb_pulse = '0;
        tick();
        bus_read(3'd2, d);
        check("held_counts", d, 32'h00010001);

        // ---------------- saturation and overflow ----------------
        for (int i = 0; i < 256; i++) pulse(4'h2);
        bus_read(3'd2, d);
        check("sat_counts", d, 32'h0001FF01);
        bus_read(3'd3, d);
        check("ovf_set", d, 32'h2);
        bus_write(3'd3, 32'h0);
        bus_read(3'd3, d);
        check("ovf_write_ignored", d, 32'h2);
        bus_write(3'd2, 32'h0);
        bus_read(3'd2, d);
        check("counts_cleared", d, 32'h0);
        bus_read(3'd3, d);
        check("ovf_cleared", d, 32'h0);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, d);
        check("unused_addr6", d, 32'h0);
        bus_read(3'd1, d);
        check("enable_readback", d, 32'h4);

        // ---------------- simultaneous set/clear ----------------
        bus_write(3'd0, 32'hF);
        pulse(4'h8);
        pb_pulse = 4'h8; sel = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h8;
        tick();
        pb_pulse = '0; sel = 1'b0; we = 1'b0; wdata = '0;
        tick();
        bus_read(3'd0, d);
        check("set_beats_w1c", d, 32'h8);
        bus_read(3'd2, d);
        check("b3_two_events", d, 32'h02000000);
        pb_pulse = 4'h8; sel = 1'b1; we = 1'b1; addr = 3'd2; wdata = 32'h0;
        tick();
        pb_pulse = '0; sel = 1'b0; we = 1'b0;
        tick();
        bus_read(3'd2, d);
        check("event_with_counts_clear", d, 32'h01000000);
        bus_write(3'd2, 32'h0);
        bus_write(3'd0, 32'hF);
        pulse(4'h3);
        bus_read(3'd0, d);
        check("multi_pending", d, 32'h3);
        bus_read(3'd2, d);
        check("multi_counts", d, 32'h00000101);

        // ---------------- read returns pre-event value ----------------
        bus_write(3'd0, 32'hF);
        pb_pulse = 4'h1; sel = 1'b1; we = 1'b0; addr = 3'd0;
        tick();
        pb_pulse = '0; sel = 1'b0;
        d = rdata;
        check("read_pre_event", d, 32'h0);
        bus_read(3'd0, d);
        check("read_post_event", d, 32'h1);

        // ---------------- timestamp option ----------------
`ifdef BTN_EVT_TIMESTAMP_EN
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 999; i++) tick();
        pulse(4'h2);
        bus_read(3'd5, d);
        check("last_id", d, 32'h1);
        bus_read(3'd4, d);
        check("last_ts_in_window", {31'b0, (d >= 32'd999 && d <= 32'd1001)}, 32'h1);
`else
        bus_read(3'd4, d);
        check("no_ts_addr4", d, 32'h0);
        bus_read(3'd5, d);
        check("no_ts_addr5", d, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
